block_writer: RTL



---
 rtl/aes_mem_pkg.sv | 18 +
 rtl/wr_addr_gen.sv | 52 +++++
 rtl/block_writer.sv | 107 ++++++++++
 3 files changed

// File: rtl/aes_mem_pkg.sv
// Shared types and constants for the AES memory path.
//   state_t     : block_writer FSM states
//   WORD_BYTES  : bytes per SRAM write word (address step)
//   BLOCK_BYTES : bytes per AES block (count step)
package aes_mem_pkg;

  localparam int unsigned WORD_BYTES  = 8;
  localparam int unsigned BLOCK_BYTES = 16;

  typedef enum logic [2:0] {
    IDLE,
    READY,
    WR_HI,
    WR_LO,
    DONE
  } state_t;

endpackage

// File: rtl/wr_addr_gen.sv
// Destination address and byte-count tracker for block_writer.
//   clk, n_rst  : clock, async active-low reset
//   load        : capture load_addr/load_len, clear byte count
//   step_word   : advance address by one word
//   step_block  : advance byte count by one block
//   addr        : current write byte address
//   addr_step_c : address of the following word
//   last_c      : count after the pending block step reaches the length
module wr_addr_gen #(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 load,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [ADDR_BITS-1:0] load_len,
  input  logic                 step_word,
  input  logic                 step_block,
  output logic [ADDR_BITS-1:0] addr,
  output logic [ADDR_BITS-1:0] addr_step_c,
  output logic                 last_c
);
  import aes_mem_pkg::*;

  localparam int unsigned CW = ADDR_BITS + 1;

  logic [CW-1:0]        count;
  logic [CW-1:0]        count_step;
  logic [ADDR_BITS-1:0] len;

  // Address wraps naturally; count has one spare bit so it cannot overflow.
  assign addr_step_c = addr + ADDR_BITS'(WORD_BYTES);
  assign count_step  = count + CW'(BLOCK_BYTES);
  assign last_c      = (count_step >= {1'b0, len});

  // Address/count registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr  <= '0;
      len   <= '0;
      count <= '0;
    end else if (load) begin
      addr  <= load_addr;
      len   <= load_len;
      count <= '0;
    end else begin
      if (step_word)  addr  <= addr_step_c;
      if (step_block) count <= count_step;
    end
  end

endmodule

// File: rtl/block_writer.sv
// Writes 128-bit AES blocks to the data SRAM as two 64-bit words.
//   clk, n_rst          : clock, async active-low reset
//   start, d_addr,length: load destination and byte length, clear progress
//   blk_valid/blk_ready : block handshake, blk_data payload
//   mem_addr/mem_wdata  : SRAM write address/data, mem_wen request
//   mem_busy            : SRAM stall, write not taken while high
//   done                : sticky, programmed length written
module block_writer #(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WORD_WIDTH  = 64,
  parameter int unsigned BLOCK_WIDTH = 128
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  input  logic [ADDR_BITS-1:0]   d_addr,
  input  logic [ADDR_BITS-1:0]   length,
  input  logic                   blk_valid,
  input  logic [BLOCK_WIDTH-1:0] blk_data,
  output logic                   blk_ready,
  output logic [ADDR_BITS-1:0]   mem_addr,
  output logic [WORD_WIDTH-1:0]  mem_wdata,
  output logic                   mem_wen,
  input  logic                   mem_busy,
  output logic                   done
);
  import aes_mem_pkg::*;

  state_t                 state;
  logic [BLOCK_WIDTH-1:0] blk_buf;
  logic [ADDR_BITS-1:0]   addr;
  logic [ADDR_BITS-1:0]   addr_step_c;
  logic                   last_c;
  logic                   take_c;

  // A word is taken on any write cycle without stall; start cancels it.
  assign take_c = ((state == WR_HI) || (state == WR_LO)) && !mem_busy && !start;

  wr_addr_gen #(
    .ADDR_BITS(ADDR_BITS)
  ) u_addr_gen (
    .clk        (clk),
    .n_rst      (n_rst),
    .load       (start),
    .load_addr  (d_addr),
    .load_len   (length),
    .step_word  (take_c),
    .step_block (take_c && (state == WR_LO)),
    .addr       (addr),
    .addr_step_c(addr_step_c),
    .last_c     (last_c)
  );

  // FSM with outputs registered alongside the state they decode
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      blk_buf   <= '0;
      blk_ready <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
    end else if (start) begin
      state     <= (length == '0) ? DONE : READY;
      blk_ready <= (length != '0);
      mem_wen   <= 1'b0;
      done      <= (length == '0);
    end else begin
      case (state)
        READY: begin
          if (blk_valid) begin
            state     <= WR_HI;
            blk_buf   <= blk_data;
            blk_ready <= 1'b0;
            mem_wen   <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= blk_data[WORD_WIDTH +: WORD_WIDTH];
          end
        end
        WR_HI: begin
          if (!mem_busy) begin
            state     <= WR_LO;
            mem_addr  <= addr_step_c;
            mem_wdata <= blk_buf[WORD_WIDTH-1:0];
          end else begin
            mem_wdata <= blk_buf[WORD_WIDTH +: WORD_WIDTH];
          end
        end
        WR_LO: begin
          if (!mem_busy) begin
            mem_wen <= 1'b0;
            if (last_c) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= READY;
              blk_ready <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
